// File: rtl/dlx_dmem.sv
// Data-memory responder for the single-cycle DLX core: word RAM, cycle counter, console FIFO.
// Define DLX_DMEM_CYCLE_CNT_EN to build the memory-mapped cycle counter; otherwise CNT reads 0.
module dlx_dmem #(
    parameter int RAM_AW  = 10,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [31:0]        ram [2**RAM_AW];
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count;
    logic               ovf;
    logic [31:0]        cnt_val;

    logic               is_ram;
    logic               is_cnt;
    logic               is_stat;
    logic               is_txd;
    logic [RAM_AW-1:0]  ram_idx;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               tx_wr;
    logic [3:0]         count4;
    logic               unused_bits;

    assign unused_bits = ^dmem_addr[1:0];

    assign is_ram  = (dmem_addr[31:28] == 4'h0);
    assign is_cnt  = (dmem_addr[31:2] == 30'h3C00_0000);
    assign is_stat = (dmem_addr[31:2] == 30'h3C00_0001);
    assign is_txd  = (dmem_addr[31:2] == 30'h3C00_0002);
    assign ram_idx = dmem_addr[RAM_AW+1:2];

    assign empty     = (count == '0);
    assign full      = (count == (FIFO_AW+1)'(DEPTH));
    assign con_valid = !empty;
    assign con_data  = fifo_mem[rptr];

    // Full is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
    assign tx_wr = dmem_we && is_txd;
    assign push  = tx_wr && !full && !rst;
    assign pop   = con_valid && con_ready;

    always_comb begin
        count4 = 4'(count);
    end

    always_ff @(posedge clk) begin
        if (dmem_we && is_ram) begin
            ram[ram_idx] <= dmem_wdata;
        end
        if (push) begin
            fifo_mem[wptr] <= dmem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + FIFO_AW'(1);
            end
            if (pop) begin
                rptr <= rptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
            if (tx_wr && full) begin
                ovf <= 1'b1;
            end else if (dmem_we && is_stat) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef DLX_DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (dmem_we && is_cnt) begin
            cycle_cnt <= dmem_wdata;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign cnt_val = cycle_cnt;
`else
    assign cnt_val = '0;
`endif

    // Reset values are forced onto the read path so they are visible before the first edge.
    always_comb begin
        dmem_rdata = '0;
        if (is_ram) begin
            dmem_rdata = ram[ram_idx];
        end else if (is_cnt) begin
            dmem_rdata = rst ? 32'h0 : cnt_val;
        end else if (is_stat) begin
            dmem_rdata = rst ? 32'h0000_0002 : {24'b0, count4, ovf, 1'b0, empty, full};
        end
    end
endmodule
